rtc_secuenciador: RTL

//  Upstream transaction sequencer for the RTC bus controller (control_salida). It initialises the RTC after reset,

---
 rtl/rtc_secuenciador_if.sv | 21 ++
 rtl/rtc_secuenciador.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rtc_secuenciador_if.sv
// Handshake bus between the RTC transaction sequencer (master) and the bus controller (slave).
// The controller's end-of-transaction pulse is carried as 'fin'.
interface rtc_secuenciador_if;
  logic       iniciar;
  logic       escribe;
  logic [7:0] direccion;
  logic [7:0] dato;
  logic       fin;
  logic       rd_n;
  logic [7:0] data_rtc;

  modport master (
    output iniciar, escribe, direccion, dato,
    input  fin, rd_n, data_rtc
  );

  modport slave (
    input  iniciar, escribe, direccion, dato,
    output fin, rd_n, data_rtc
  );
endinterface

// File: rtl/rtc_secuenciador.sv
// RTC transaction sequencer: initialises the RTC, then periodically latches and reads the
// nine time/timer registers, inserting user writes between read bursts.
module rtc_secuenciador #(
  parameter logic [15:0] PAUSA   = 16'd1000,
  parameter logic [7:0]  TIMEOUT = 8'd63
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      programar,
  input  logic [7:0]                dir_prog,
  input  logic [7:0]                dato_prog,
  rtc_secuenciador_if.master        bus,
  output logic [7:0]                seg,
  output logic [7:0]                min,
  output logic [7:0]                hora,
  output logic [7:0]                dia,
  output logic [7:0]                mes,
  output logic [7:0]                anio,
  output logic [7:0]                tseg,
  output logic [7:0]                tmin,
  output logic [7:0]                thora,
  output logic                      actualizado,
  output logic                      ack_prog,
  output logic                      ocupado,
  output logic                      error_bus
);

  typedef enum logic [2:0] {
    S_INI_A, S_INI_B, S_PAUSA, S_TRANSF, S_LECTURA, S_ESCRITURA, S_SOLTAR
  } estado_t;

  estado_t     estado, estado_sig, destino, tras;
  logic [3:0]  idx;
  logic [15:0] cuenta;
  logic [7:0]  espera;
  logic [7:0]  cap;
  logic [7:0]  lect [9];
  logic        pend, prog_q;
  logic [7:0]  dir_pend, dato_pend;
  logic [7:0]  dir_ini, dato_ini;
  logic        en_trans, arranque, fin_ok, vencido, fin_paso;

  function automatic logic [7:0] dir_lectura(input logic [3:0] i);
    case (i)
      4'd0:    dir_lectura = 8'h21;
      4'd1:    dir_lectura = 8'h22;
      4'd2:    dir_lectura = 8'h23;
      4'd3:    dir_lectura = 8'h24;
      4'd4:    dir_lectura = 8'h25;
      4'd5:    dir_lectura = 8'h26;
      4'd6:    dir_lectura = 8'h41;
      4'd7:    dir_lectura = 8'h42;
      default: dir_lectura = 8'h43;
    endcase
  endfunction

  // Every transaction state starts with iniciar low (entry cycle) and returns through
  // S_SOLTAR, which guarantees the idle gap before the next transaction.
  always_comb begin
    en_trans   = (estado != S_PAUSA) && (estado != S_SOLTAR);
    arranque   = en_trans && !bus.iniciar;
    fin_ok     = en_trans && bus.iniciar && bus.fin;
    vencido    = en_trans && bus.iniciar && !bus.fin && (espera == TIMEOUT - 8'd1);
    fin_paso   = fin_ok || vencido;
    estado_sig = estado;
    tras       = S_PAUSA;
    dir_ini    = '0;
    dato_ini   = '0;
    case (estado)
      S_INI_A:     begin dir_ini = 8'h02; dato_ini = 8'h10; tras = S_INI_B; end
      S_INI_B:     begin dir_ini = 8'h02; dato_ini = 8'h00; tras = S_PAUSA; end
      S_TRANSF:    begin dir_ini = 8'hF0; dato_ini = 8'hF0; tras = S_LECTURA; end
      S_LECTURA:   begin
        dir_ini = dir_lectura(idx);
        tras    = (idx == 4'd8) ? S_PAUSA : S_LECTURA;
      end
      S_ESCRITURA: begin dir_ini = dir_pend; dato_ini = dato_pend; tras = S_PAUSA; end
      S_PAUSA: begin
        if (pend)                             estado_sig = S_ESCRITURA;
        else if (cuenta == PAUSA - 16'd1)     estado_sig = S_TRANSF;
      end
      S_SOLTAR:    estado_sig = destino;
      default:     estado_sig = S_INI_A;
    endcase
    if (fin_paso) estado_sig = S_SOLTAR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= S_INI_A;
      destino       <= S_INI_A;
      bus.iniciar   <= 1'b0;
      bus.escribe   <= 1'b0;
      bus.direccion <= '0;
      bus.dato      <= '0;
      espera        <= '0;
      cuenta        <= '0;
      idx           <= '0;
      cap           <= '0;
      for (int unsigned i = 0; i < 9; i++) lect[i] <= '0;
      pend          <= 1'b0;
      prog_q        <= 1'b0;
      dir_pend      <= '0;
      dato_pend     <= '0;
      actualizado   <= 1'b0;
      ack_prog      <= 1'b0;
      ocupado       <= 1'b0;
      error_bus     <= 1'b0;
    end else begin
      estado      <= estado_sig;
      ocupado     <= (estado_sig != S_PAUSA);
      actualizado <= 1'b0;
      ack_prog    <= 1'b0;
      prog_q      <= programar;

      // Edge-triggered so a request held high is serviced only once.
      if (programar && !prog_q && !pend) begin
        pend      <= 1'b1;
        dir_pend  <= dir_prog;
        dato_pend <= dato_prog;
      end

      if (estado == S_PAUSA && estado_sig == S_PAUSA) cuenta <= cuenta + 16'd1;
      else                                            cuenta <= '0;

      if (estado == S_LECTURA && !bus.rd_n) cap <= bus.data_rtc;

      if (arranque) begin
        bus.iniciar   <= 1'b1;
        bus.escribe   <= (estado != S_LECTURA);
        bus.direccion <= dir_ini;
        bus.dato      <= dato_ini;
        espera        <= '0;
      end else if (fin_paso) begin
        bus.iniciar <= 1'b0;
        destino     <= tras;
        if (vencido) error_bus <= 1'b1;
        if (estado == S_LECTURA) begin
          if (fin_ok) lect[idx] <= bus.rd_n ? cap : bus.data_rtc;
          if (idx == 4'd8) begin
            idx         <= '0;
            actualizado <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        if (estado == S_ESCRITURA) begin
          pend     <= 1'b0;
          ack_prog <= fin_ok;
        end
      end else if (bus.iniciar) begin
        espera <= espera + 8'd1;
      end
    end
  end

  assign seg   = lect[0];
  assign min   = lect[1];
  assign hora  = lect[2];
  assign dia   = lect[3];
  assign mes   = lect[4];
  assign anio  = lect[5];
  assign tseg  = lect[6];
  assign tmin  = lect[7];
  assign thora = lect[8];

endmodule
